low_fir_mac: RTL and testbench

Stereo FIR multiply-accumulate stage directly downstream of the low-frequency sample queue. Each time the queue asserts `sequencing`, the block does the following:

- Consumes the burst of left/right samples read out of the queue.
- Multiplies each sample by a Q1.15 coefficient fetched from an external synchronous coefficient ROM.
- Accumulates the products.
- Presents one filtered 16-bit left/right result with a single-cycle valid pulse to the band-gain/summing stage.

---
 rtl/low_fir_mac.sv | 161 ++++++++++++++++
 tb/tb_low_fir_mac.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/low_fir_mac.sv
`default_nettype none
// ============================================================================
// Module   : low_fir_mac
// Purpose  : Stereo Q1.15 FIR multiply-accumulate over one queue burst per
//            sequencing window. Define LOW_FIR_SAT_EN to saturate the outputs
//            instead of truncating them.
// Revision : 1.0 - initial release
// ============================================================================

module low_fir_mac #(
    parameter int TAPS  = 1021,
    parameter int ACC_W = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sequencing,
    input  logic signed [15:0] lft_in,
    input  logic signed [15:0] rght_in,
    output logic        [9:0]  coeff_addr,
    input  logic signed [15:0] coeff,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rght_out,
    output logic               out_vld,
    output logic               tap_err
);

    localparam int               CNT_W    = $clog2(TAPS + 2) + 1;
    localparam logic [CNT_W-1:0] TAPS_CNT = CNT_W'(TAPS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   state_q;
    logic [9:0]               addr_q;
    logic [9:0]               addr_d;
    logic                     seq_dly_q;
    logic                     armed_q;
    logic signed [ACC_W-1:0]  acc_l_q;
    logic signed [ACC_W-1:0]  acc_r_q;
    logic [CNT_W-1:0]         tap_cnt_q;
    logic [15:0]              lft_q;
    logic [15:0]              rght_q;
    logic                     vld_q;
    logic                     err_q;

    logic signed [31:0]       prod_l;
    logic signed [31:0]       prod_r;
    logic signed [ACC_W-1:0]  term_l;
    logic signed [ACC_W-1:0]  term_r;
    logic [15:0]              res_l;
    logic [15:0]              res_r;

    // ROM address runs while the window is open and parks at zero otherwise.
    always_comb begin
        addr_d = sequencing ? addr_q + 10'd1 : 10'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= 10'd0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign prod_l = 32'(lft_in)  * 32'(coeff);
    assign prod_r = 32'(rght_in) * 32'(coeff);
    assign term_l = ACC_W'(prod_l);
    assign term_r = ACC_W'(prod_r);

`ifdef LOW_FIR_SAT_EN
    logic [ACC_W-31:0] hi_l;
    logic [ACC_W-31:0] hi_r;

    assign hi_l = acc_l_q[ACC_W-1:30];
    assign hi_r = acc_r_q[ACC_W-1:30];

    // Bits above the Q1.15 window must all match the sign, else clamp.
    always_comb begin
        res_l = acc_l_q[30:15];
        res_r = acc_r_q[30:15];
        if (!((&hi_l) || !(|hi_l))) begin
            res_l = acc_l_q[ACC_W-1] ? 16'h8000 : 16'h7FFF;
        end
        if (!((&hi_r) || !(|hi_r))) begin
            res_r = acc_r_q[ACC_W-1] ? 16'h8000 : 16'h7FFF;
        end
    end
`else
    always_comb begin
        res_l = acc_l_q[30:15];
        res_r = acc_r_q[30:15];
    end
`endif

    // armed_q blocks the tail of a burst interrupted by reset from being
    // treated as a new burst; it arms once sequencing has been seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            seq_dly_q <= 1'b0;
            armed_q   <= 1'b0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            tap_cnt_q <= '0;
            lft_q     <= 16'h0000;
            rght_q    <= 16'h0000;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            seq_dly_q <= sequencing;
            armed_q   <= armed_q | ~sequencing;
            vld_q     <= 1'b0;
            case (state_q)
                // DONE also accepts a burst whose first sample lands in it.
                S_IDLE, S_DONE: begin
                    if (seq_dly_q && armed_q) begin
                        acc_l_q   <= term_l;
                        acc_r_q   <= term_r;
                        tap_cnt_q <= CNT_W'(1);
                        state_q   <= S_ACCUM;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_ACCUM: begin
                    if (seq_dly_q) begin
                        acc_l_q <= acc_l_q + term_l;
                        acc_r_q <= acc_r_q + term_r;
                        if (tap_cnt_q != {CNT_W{1'b1}}) begin
                            tap_cnt_q <= tap_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        lft_q   <= res_l;
                        rght_q  <= res_r;
                        vld_q   <= 1'b1;
                        if (tap_cnt_q != TAPS_CNT) begin
                            err_q <= 1'b1;
                        end
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign coeff_addr = addr_q;
    assign lft_out    = lft_q;
    assign rght_out   = rght_q;
    assign out_vld    = vld_q;
    assign tap_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_low_fir_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_low_fir_mac
// Purpose  : Self-checking bench for low_fir_mac: acts as sample queue and
//            coefficient ROM, predicts each burst result as a plain dot product.
// Revision : 1.0 - initial release
// ============================================================================

module tb_low_fir_mac;

    localparam int TAPS = 1021;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        sequencing = 1'b0;
    logic [15:0] lft_in     = 16'h0000;
    logic [15:0] rght_in    = 16'h0000;
    logic [15:0] coeff      = 16'h0000;
    logic [9:0]  coeff_addr;
    logic [15:0] lft_out;
    logic [15:0] rght_out;
    logic        out_vld;
    logic        tap_err;

    low_fir_mac #(.TAPS(TAPS), .ACC_W(40)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sequencing (sequencing),
        .lft_in     (lft_in),
        .rght_in    (rght_in),
        .coeff_addr (coeff_addr),
        .coeff      (coeff),
        .lft_out    (lft_out),
        .rght_out   (rght_out),
        .out_vld    (out_vld),
        .tap_err    (tap_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] l;
        logic [15:0] r;
        bit          err;
    } exp_t;

    exp_t        q[$];
    int          checks     = 0;
    int          failures   = 0;
    int          cyc        = 0;
    int          npulse     = 0;
    int          last_pulse = 0;
    logic [15:0] rom [0:1023];
    logic [15:0] sl  [0:2047];
    logic [15:0] sr  [0:2047];
    logic [15:0] pend_l = 16'h0000;
    logic [15:0] pend_r = 16'h0000;
    logic [15:0] m_l    = 16'h0000;
    logic [15:0] m_r    = 16'h0000;
    bit          m_err  = 1'b0;
    logic [9:0]  addr_m = 10'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous coefficient ROM, one-cycle read latency.
    always @(posedge clk) coeff <= rom[coeff_addr];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] q15(input longint a);
`ifdef LOW_FIR_SAT_EN
        if (a > 64'sd1073741823)  return 16'h7FFF;
        if (a < -64'sd1073741824) return 16'h8000;
`endif
        return 16'(a >>> 15);
    endfunction

    // Per-cycle comparison against the model state.
    always @(negedge clk) begin
        if (out_vld === 1'b1) begin
            npulse++;
            last_pulse = cyc;
        end
        if (!rst_n) begin
            check("rst_lft", 32'(lft_out), 32'h0);
            check("rst_rght", 32'(rght_out), 32'h0);
            check("rst_vld", 32'(out_vld), 32'h0);
            check("rst_addr", 32'(coeff_addr), 32'h0);
            check("rst_err", 32'(tap_err), 32'h0);
            m_l    = 16'h0000;
            m_r    = 16'h0000;
            m_err  = 1'b0;
            addr_m = 10'd0;
        end else begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                check("vld_pulse", 32'(out_vld), 32'h1);
                m_l   = q[0].l;
                m_r   = q[0].r;
                m_err = m_err | q[0].err;
                void'(q.pop_front());
            end else begin
                check("vld_idle", 32'(out_vld), 32'h0);
            end
            check("lft_out", 32'(lft_out), 32'(m_l));
            check("rght_out", 32'(rght_out), 32'(m_r));
            check("tap_err", 32'(tap_err), 32'(m_err));
            check("coeff_addr", 32'(coeff_addr), 32'(addr_m));
            addr_m = sequencing ? addr_m + 10'd1 : 10'd0;
        end
    end

    // One clock of queue activity; read data follows its address by a cycle.
    task automatic step(input bit s, input logic [15:0] l, input logic [15:0] r);
        @(posedge clk);
        #1;
        sequencing = s;
        lft_in     = pend_l;
        rght_in    = pend_r;
        pend_l     = s ? l : 16'h0000;
        pend_r     = s ? r : 16'h0000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic burst(input int n, output int p_last);
        longint al = 0;
        longint ar = 0;
        exp_t   e;
        for (int k = 0; k < n; k++) begin
            step(1'b1, sl[k], sr[k]);
            al += longint'($signed(sl[k])) * longint'($signed(rom[k % 1024]));
            ar += longint'($signed(sr[k])) * longint'($signed(rom[k % 1024]));
        end
        p_last = cyc;
        e.cyc  = p_last + 3;
        e.l    = q15(al);
        e.r    = q15(ar);
        e.err  = (n != TAPS);
        q.push_back(e);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
    endtask

    task automatic rand_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom_range(0, 4095) - 2048);
    endtask

    task automatic rand_smp();
        for (int i = 0; i < 2048; i++) begin
            sl[i] = 16'($urandom);
            sr[i] = 16'($urandom);
        end
    endtask

    initial begin
        int pl;
        int n0;
        clear_rom();
        rand_smp();
        idle(3);
        rst_n = 1'b1;
        check("init_lft", 32'(lft_out), 32'h0);
        check("init_vld", 32'(out_vld), 32'h0);
        check("init_err", 32'(tap_err), 32'h0);
        idle(4);

        // Single-tap impulse
        rom[0] = 16'h4000;
        sl[0]  = 16'h2000;
        sr[0]  = 16'hE000;
        burst(TAPS, pl);
        idle(4);
        check("imp_lft", 32'(lft_out), 32'h1000);
        check("imp_rght", 32'(rght_out), 32'hF000);
        check("imp_err", 32'(tap_err), 32'h0);
        check("imp_latency", 32'(last_pulse - (pl + 1)), 32'd2);
        check("imp_addr_home", 32'(coeff_addr), 32'h0);

        // Random full-length burst
        rand_rom();
        rand_smp();
        burst(TAPS, pl);
        idle(4);

        // Back-to-back bursts with a DC input
        clear_rom();
        rom[0] = 16'h7FFF;
        for (int i = 0; i < 2048; i++) begin
            sl[i] = 16'h1000;
            sr[i] = 16'h1000;
        end
        n0 = npulse;
        burst(TAPS, pl);
        idle(1);
        burst(TAPS, pl);
        idle(4);
        check("b2b_pulses", 32'(npulse - n0), 32'd2);
        check("b2b_lft", 32'(lft_out), 32'h0FFF);
        check("b2b_rght", 32'(rght_out), 32'h0FFF);
        check("b2b_err", 32'(tap_err), 32'h0);

        // Reset at tap 500, with sequencing still high across the release
        rand_rom();
        rand_smp();
        n0 = npulse;
        for (int k = 0; k < 500; k++) step(1'b1, sl[k], sr[k]);
        rst_n = 1'b0;
        for (int k = 500; k < 503; k++) step(1'b1, sl[k], sr[k]);
        rst_n = 1'b1;
        for (int k = 503; k < 508; k++) step(1'b1, sl[k], sr[k]);
        idle(6);
        check("abort_no_pulse", 32'(npulse - n0), 32'd0);
        rand_smp();
        burst(TAPS, pl);
        idle(4);
        check("post_rst_pulse", 32'(npulse - n0), 32'd1);
        check("post_rst_err", 32'(tap_err), 32'h0);

        // Overflow with a short burst
        clear_rom();
        rom[0] = 16'h7FFF;
        rom[1] = 16'h7FFF;
        sl[0]  = 16'h7FFF;
        sl[1]  = 16'h7FFF;
        sr[0]  = 16'h8001;
        sr[1]  = 16'h8001;
        burst(2, pl);
        idle(4);
`ifdef LOW_FIR_SAT_EN
        check("ovf_lft", 32'(lft_out), 32'h7FFF);
`else
        check("ovf_lft", 32'(lft_out), 32'hFFFC);
`endif
        check("ovf_err", 32'(tap_err), 32'h1);

        // Single-sample burst, then a long burst that wraps the address
        rand_rom();
        rand_smp();
        burst(1, pl);
        idle(4);
        check("single_err", 32'(tap_err), 32'h1);
        burst(1030, pl);
        idle(4);

        // Only reset clears the sticky error
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        check("final_err", 32'(tap_err), 32'h0);
        check("pending_results", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
